// File: rtl/evg_hw_trigger_arbiter.sv
// Hardware trigger front end: per-channel sync/debounce/edge detect feeding a
// single-beat event arbiter (fixed or round-robin) onto a valid/ready stream.

module evg_hw_trigger_channel #(
  parameter int EVENTCODE_WIDTH = 8,
  parameter int DEBOUNCE_WIDTH  = 8
) (
  input  logic                       evgTxClk,
  input  logic                       evgTxReset,
  input  logic                       trigA,
  input  logic                       cfgWe,
  input  logic [EVENTCODE_WIDTH+2:0] cfgData,
  input  logic [DEBOUNCE_WIDTH-1:0]  debounceLimit,
  input  logic                       grant,
  input  logic                       overrunClear,
  output logic                       pending,
  output logic [EVENTCODE_WIDTH-1:0] code,
  output logic                       overrun
);
  typedef struct packed {
    logic                       enable;
    logic [1:0]                 edgeSel;
    logic [EVENTCODE_WIDTH-1:0] code;
  } cfg_t;

  cfg_t                      cfgQ, cfgIn;
  logic [1:0]                syncQ;
  logic                      lvlQ, armedQ;
  logic [DEBOUNCE_WIDTH-1:0] cntQ;
  logic [DEBOUNCE_WIDTH:0]   limEff, cntInc;
  logic                      accept, edgeMatch, edgeHit, cfgKill;

  assign cfgIn     = cfg_t'(cfgData);
  assign limEff    = (debounceLimit == '0) ? (DEBOUNCE_WIDTH+1)'(1) : {1'b0, debounceLimit};
  assign cntInc    = {1'b0, cntQ} + (DEBOUNCE_WIDTH+1)'(1);
  // Accept on the cycle the counter would reach the limit, so a clean step
  // lands 2 + limit cycles after the pin moves.
  assign accept    = (syncQ[1] != lvlQ) && (cntInc >= limEff);
  assign edgeMatch = cfgQ.edgeSel[1] || (cfgQ.edgeSel[0] == syncQ[1]);
  assign edgeHit   = accept && !armedQ && edgeMatch && cfgQ.enable && (cfgQ.code != '0);
  assign cfgKill   = cfgWe && (!cfgIn.enable || (cfgIn.code == '0));
  assign code      = cfgQ.code;

  always_ff @(posedge evgTxClk) begin
    if (evgTxReset) begin
      syncQ   <= '0;
      lvlQ    <= 1'b0;
      armedQ  <= 1'b1;
      cntQ    <= '0;
      cfgQ    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], trigA};
      if (accept) begin
        lvlQ   <= syncQ[1];
        armedQ <= 1'b0;
        cntQ   <= '0;
      end else if (syncQ[1] == lvlQ) begin
        cntQ <= '0;
      end else begin
        cntQ <= cntInc[DEBOUNCE_WIDTH-1:0];
      end
      if (cfgWe) cfgQ <= cfgIn;
      // A new edge outranks the grant clearing it: the request is re-armed.
      if (cfgKill)      pending <= 1'b0;
      else if (edgeHit) pending <= 1'b1;
      else if (grant)   pending <= 1'b0;
      if (edgeHit && pending && !grant) overrun <= 1'b1;
      else if (overrunClear)            overrun <= 1'b0;
    end
  end
endmodule

module evg_hw_trigger_arbiter #(
  parameter int CHANNEL_COUNT   = 8,
  parameter int EVENTCODE_WIDTH = 8,
  parameter int DEBOUNCE_WIDTH  = 8,
  localparam int AW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                       evgTxClk,
  input  logic                       evgTxReset,
  input  logic [CHANNEL_COUNT-1:0]   hwTriggers_a,
  input  logic                       cfgStrobe,
  input  logic [AW-1:0]              cfgAddr,
  input  logic [EVENTCODE_WIDTH+2:0] cfgData,
  output logic [EVENTCODE_WIDTH+2:0] cfgRbk,
  input  logic [DEBOUNCE_WIDTH-1:0]  debounceLimit,
  input  logic                       arbMode,
  input  logic [CHANNEL_COUNT-1:0]   overrunClear,
  output logic [CHANNEL_COUNT-1:0]   overrun,
  output logic [EVENTCODE_WIDTH-1:0] evgHardwareEventTDATA,
  output logic                       evgHardwareEventTVALID,
  input  logic                       evgHardwareEventTREADY
);
  logic [CHANNEL_COUNT-1:0]                      pend, grantOh, cfgWe;
  logic [CHANNEL_COUNT-1:0][EVENTCODE_WIDTH-1:0] codes;
  logic [AW-1:0]                                 lastGrant, grantIdx;
  logic                                          addrOk, doGrant, rrFound;
  int                                            rrIdx;

  assign addrOk  = 32'(cfgAddr) < CHANNEL_COUNT;
  assign doGrant = !evgHardwareEventTVALID && (|pend);
  assign grantOh = doGrant ? (CHANNEL_COUNT'(1) << grantIdx) : '0;

  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : gCh
    assign cfgWe[g] = cfgStrobe && addrOk && (cfgAddr == AW'(g));
    evg_hw_trigger_channel #(
      .EVENTCODE_WIDTH(EVENTCODE_WIDTH),
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) uCh (
      .evgTxClk     (evgTxClk),
      .evgTxReset   (evgTxReset),
      .trigA        (hwTriggers_a[g]),
      .cfgWe        (cfgWe[g]),
      .cfgData      (cfgData),
      .debounceLimit(debounceLimit),
      .grant        (grantOh[g]),
      .overrunClear (overrunClear[g]),
      .pending      (pend[g]),
      .code         (codes[g]),
      .overrun      (overrun[g])
    );
  end

  // Fixed: last hit in an ascending scan is the highest index.
  // Round-robin: first hit scanning upward from lastGrant+1 with wrap.
  always_comb begin
    grantIdx = '0;
    rrFound  = 1'b0;
    rrIdx    = 0;
    if (!arbMode) begin
      for (int i = 0; i < CHANNEL_COUNT; i++)
        if (pend[i]) grantIdx = AW'(i);
    end else begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        rrIdx = (int'(lastGrant) + 1 + i) % CHANNEL_COUNT;
        if (!rrFound && pend[rrIdx]) begin
          grantIdx = AW'(rrIdx);
          rrFound  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge evgTxClk) begin
    if (evgTxReset) begin
      evgHardwareEventTVALID <= 1'b0;
      evgHardwareEventTDATA  <= '0;
      lastGrant              <= AW'(CHANNEL_COUNT - 1);
      cfgRbk                 <= '0;
    end else begin
      if (evgHardwareEventTVALID) begin
        if (evgHardwareEventTREADY) evgHardwareEventTVALID <= 1'b0;
      end else if (doGrant) begin
        evgHardwareEventTVALID <= 1'b1;
        evgHardwareEventTDATA  <= codes[grantIdx];
        lastGrant              <= grantIdx;
      end
      // Config only changes on a strobe, so the written word is the readback.
      if (cfgStrobe) cfgRbk <= addrOk ? cfgData : '0;
    end
  end
endmodule

// File: tb/tb_evg_hw_trigger_arbiter.sv
// Bench for evg_hw_trigger_arbiter: config/latency tables plus scoreboarded
// event stream covering arbitration, backpressure, overrun and reset corners.

module tb_evg_hw_trigger_arbiter;
  localparam int N  = 7;
  localparam int EW = 8;
  localparam int DW = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            evgTxReset;
  logic [N-1:0]    hw;
  logic            cfgStrobe;
  logic [AW-1:0]   cfgAddr;
  logic [EW+2:0]   cfgData, cfgRbk;
  logic [DW-1:0]   debounceLimit;
  logic            arbMode;
  logic [N-1:0]    overrunClear, overrun;
  logic [EW-1:0]   tdata;
  logic            tvalid, tready;

  int              checks = 0;
  int              errors = 0;
  logic [EW-1:0]   expQ[$];
  logic [EW-1:0]   expCode;
  int              n;

  typedef struct { logic [AW-1:0] addr; logic [EW+2:0] data; logic [EW+2:0] exp; } cfgVec_t;
  typedef struct { logic [DW-1:0] lim; int lat; } latVec_t;
  cfgVec_t cfgTbl[5];
  latVec_t latTbl[5];

  always #5 clk = ~clk;

  evg_hw_trigger_arbiter #(.CHANNEL_COUNT(N), .EVENTCODE_WIDTH(EW), .DEBOUNCE_WIDTH(DW)) dut (
    .evgTxClk              (clk),
    .evgTxReset            (evgTxReset),
    .hwTriggers_a          (hw),
    .cfgStrobe             (cfgStrobe),
    .cfgAddr               (cfgAddr),
    .cfgData               (cfgData),
    .cfgRbk                (cfgRbk),
    .debounceLimit         (debounceLimit),
    .arbMode               (arbMode),
    .overrunClear          (overrunClear),
    .overrun               (overrun),
    .evgHardwareEventTDATA (tdata),
    .evgHardwareEventTVALID(tvalid),
    .evgHardwareEventTREADY(tready)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [AW-1:0] a, input logic en, input logic [1:0] es, input logic [EW-1:0] c);
    cfgAddr = a; cfgData = {en, es, c}; cfgStrobe = 1'b1;
    tick(1);
    cfgStrobe = 1'b0;
  endtask

  task automatic measure(input int maxc, output int cyc);
    cyc = 0;
    while (!tvalid && cyc < maxc) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic holdChk(input int k);
    repeat (k) begin
      tick(1);
      check("holdValid", tvalid, 1);
      check("holdData", tdata, 8'h11);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest expected code.
  always @(negedge clk) begin
    if (!evgTxReset && tvalid && tready) begin
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpectedBeat: got tdata=%0h, required no beat", tdata);
      end else begin
        expCode = expQ.pop_front();
        check("beat", tdata, expCode);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    cfgTbl[0] = '{3'd3, {1'b1, 2'b00, 8'h2A}, {1'b1, 2'b00, 8'h2A}};
    cfgTbl[1] = '{3'd7, {1'b1, 2'b01, 8'h77}, 11'h000};
    cfgTbl[2] = '{3'd0, {1'b1, 2'b01, 8'h11}, {1'b1, 2'b01, 8'h11}};
    cfgTbl[3] = '{3'd6, {1'b1, 2'b10, 8'h66}, {1'b1, 2'b10, 8'h66}};
    cfgTbl[4] = '{3'd5, {1'b0, 2'b11, 8'h55}, {1'b0, 2'b11, 8'h55}};
    latTbl[0] = '{8'd0, 4};
    latTbl[1] = '{8'd1, 4};
    latTbl[2] = '{8'd2, 5};
    latTbl[3] = '{8'd5, 8};
    latTbl[4] = '{8'd9, 12};

    evgTxReset = 1'b1; hw = '0; cfgStrobe = 1'b0; cfgAddr = '0; cfgData = '0;
    debounceLimit = 8'd4; arbMode = 1'b0; overrunClear = '0; tready = 1'b1;
    tick(3);
    evgTxReset = 1'b0;
    check("rstValid", tvalid, 0);
    check("rstData", tdata, 0);
    check("rstOverrun", overrun, 0);
    check("rstRbk", cfgRbk, 0);

    // Config write / readback, including an out-of-range address
    for (int i = 0; i < 5; i++) begin
      cfgAddr = cfgTbl[i].addr; cfgData = cfgTbl[i].data; cfgStrobe = 1'b1;
      tick(1);
      cfgStrobe = 1'b0;
      check("cfgRbk", cfgRbk, cfgTbl[i].exp);
    end

    // Channel 3 falling edge, limit 4
    cfgWrite(3, 1'b1, 2'b00, 8'h2A);
    hw[3] = 1'b1; tick(10);
    check("firstAcceptNoEvent", tvalid, 0);
    expQ.push_back(8'h2A);
    hw[3] = 1'b0;
    measure(20, n);
    check("lat36", n, 7);
    check("tdata36", tdata, 8'h2A);
    tick(6);
    check("oneBeat36", tvalid, 0);

    // Glitch shorter than the debounce limit
    hw[3] = 1'b1; tick(10);
    hw[3] = 1'b0; tick(3);
    hw[3] = 1'b1; tick(15);
    check("glitchValid", tvalid, 0);
    check("glitchOverrun", overrun, 0);

    // Debounce latency across limits (0 behaves as 1)
    cfgWrite(2, 1'b1, 2'b10, 8'h22);
    hw[2] = 1'b1; tick(10);
    for (int i = 0; i < 5; i++) begin
      debounceLimit = latTbl[i].lim;
      expQ.push_back(8'h22);
      hw[2] = ~hw[2];
      measure(30, n);
      check("latTbl", n, latTbl[i].lat);
      tick(4);
    end

    // Fixed priority: 1,5,6 together -> 6,5,1
    debounceLimit = 8'd1;
    cfgWrite(1, 1'b1, 2'b01, 8'h11);
    cfgWrite(5, 1'b1, 2'b01, 8'h55);
    cfgWrite(6, 1'b1, 2'b01, 8'h66);
    hw[1] = 1'b1; hw[5] = 1'b1; hw[6] = 1'b1; tick(6);
    hw[1] = 1'b0; hw[5] = 1'b0; hw[6] = 1'b0; tick(6);
    expQ.push_back(8'h66); expQ.push_back(8'h55); expQ.push_back(8'h11);
    hw[1] = 1'b1; hw[5] = 1'b1; hw[6] = 1'b1; tick(15);
    check("fixedDrained", expQ.size(), 0);

    // Round-robin after lastGrant=5 -> 6,1,5
    hw[1] = 1'b0; hw[5] = 1'b0; hw[6] = 1'b0; tick(6);
    arbMode = 1'b1;
    expQ.push_back(8'h55);
    hw[5] = 1'b1; tick(8);
    hw[5] = 1'b0; tick(6);
    expQ.push_back(8'h66); expQ.push_back(8'h11); expQ.push_back(8'h55);
    hw[1] = 1'b1; hw[5] = 1'b1; hw[6] = 1'b1; tick(15);
    check("rrDrained", expQ.size(), 0);

    // Backpressure: re-edge on granted ch1 (no overrun), double edge on ch5
    arbMode = 1'b0;
    hw[1] = 1'b0; hw[5] = 1'b0; tick(6);
    tready = 1'b0;
    expQ.push_back(8'h11);
    hw[1] = 1'b1; tick(6);
    check("bpValid", tvalid, 1);
    check("bpData", tdata, 8'h11);
    hw[5] = 1'b1; holdChk(5);
    hw[1] = 1'b0; holdChk(4);
    hw[1] = 1'b1; holdChk(4);
    hw[5] = 1'b0; holdChk(4);
    hw[5] = 1'b1; holdChk(4);
    check("bpOverrun", overrun, 7'h20);
    expQ.push_back(8'h55); expQ.push_back(8'h11);
    tready = 1'b1; tick(10);
    check("bpDrained", expQ.size(), 0);
    overrunClear = 7'h20; tick(1);
    overrunClear = '0;
    check("overrunCleared", overrun, 0);

    // Disabled channel and code 0 produce nothing, and no stale event later
    cfgWrite(4, 1'b0, 2'b01, 8'h44);
    hw[4] = 1'b1; tick(6); hw[4] = 1'b0; tick(6); hw[4] = 1'b1; tick(6);
    cfgWrite(4, 1'b1, 2'b01, 8'h44); tick(10);
    check("noStaleValid", tvalid, 0);
    cfgWrite(0, 1'b1, 2'b01, 8'h00);
    hw[0] = 1'b1; tick(6); hw[0] = 1'b0; tick(6); hw[0] = 1'b1; tick(6);
    check("code0Valid", tvalid, 0);
    check("code0Overrun", overrun, 0);

    // Disabling a pending channel withdraws its request
    tready = 1'b0;
    hw[4] = 1'b0; tick(6);
    expQ.push_back(8'h44);
    hw[4] = 1'b1; tick(6);
    hw[4] = 1'b0; tick(6);
    hw[4] = 1'b1; tick(6);
    cfgWrite(4, 1'b0, 2'b01, 8'h44);
    tready = 1'b1; tick(10);
    check("disableDrained", expQ.size(), 0);

    // Reset mid-handshake
    cfgWrite(2, 1'b1, 2'b10, 8'h22);
    tready = 1'b0;
    hw[2] = ~hw[2]; tick(6);
    check("preRstValid", tvalid, 1);
    hw[6] = 1'b0; tick(6); hw[6] = 1'b1; tick(6);
    evgTxReset = 1'b1; tick(1);
    check("midRstValid", tvalid, 0);
    check("midRstData", tdata, 0);
    check("midRstOverrun", overrun, 0);
    check("midRstRbk", cfgRbk, 0);
    evgTxReset = 1'b0;
    hw = '1;
    cfgWrite(2, 1'b1, 2'b10, 8'h22);
    cfgWrite(6, 1'b1, 2'b01, 8'h66);
    tready = 1'b1; tick(20);
    check("postRstValid", tvalid, 0);
    check("finalQueue", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
